// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALUdec+ALU pair between the
// branch/compare unit (port 0) and the address-generation unit (port 1).
module alu_arbiter #(
  parameter int unsigned TAGW = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            Clock,
  input  logic            Reset_n,

  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [6:0]      in0_opcode,
  input  logic [2:0]      in0_funct,
  input  logic            in0_add_rshift_type,
  input  logic [31:0]     in0_A,
  input  logic [31:0]     in0_B,
  input  logic [TAGW-1:0] in0_tag,

  input  logic            in1_valid,
  output logic            in1_ready,
  input  logic [6:0]      in1_opcode,
  input  logic [2:0]      in1_funct,
  input  logic            in1_add_rshift_type,
  input  logic [31:0]     in1_A,
  input  logic [31:0]     in1_B,
  input  logic [TAGW-1:0] in1_tag,

  output logic [6:0]      alu_opcode,
  output logic [2:0]      alu_funct,
  output logic            alu_add_rshift_type,
  output logic [31:0]     alu_A,
  output logic [31:0]     alu_B,
  input  logic [31:0]     alu_Out,
  input  logic            alu_Zero,

  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [31:0]     resp0_data,
  output logic            resp0_zero,
  output logic [TAGW-1:0] resp0_tag,

  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [31:0]     resp1_data,
  output logic            resp1_zero,
  output logic [TAGW-1:0] resp1_tag,

  output logic            busy,
  output logic [CNTW-1:0] stall_cnt
);

  logic            s1_valid_q, s1_valid_d;
  logic            s1_owner_q, s1_owner_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct_q, funct_d;
  logic            ars_q, ars_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic [1:0]      rvalid_q, rvalid_d;
  logic [31:0]     rdata_q [2];
  logic [31:0]     rdata_d [2];
  logic [1:0]      rzero_q, rzero_d;
  logic [TAGW-1:0] rtag_q [2];
  logic [TAGW-1:0] rtag_d [2];

  logic            last_grant_q, last_grant_d;
  logic [CNTW-1:0] stall_q, stall_d;

  logic [1:0]      resp_ready_v;
  logic            s1_adv;
  logic            can_accept;
  logic            grant0;
  logic            grant1;

  always_comb begin
    resp_ready_v = {resp1_ready, resp0_ready};
    s1_adv       = s1_valid_q & (~rvalid_q[s1_owner_q] | resp_ready_v[s1_owner_q]);
    can_accept   = ~s1_valid_q | s1_adv;
    // last_grant_q==1 means port 1 went last, so port 0 wins a tie
    grant0       = in0_valid & (~in1_valid | last_grant_q);
    grant1       = in1_valid & (~in0_valid | ~last_grant_q);
    in0_ready    = can_accept & grant0;
    in1_ready    = can_accept & grant1;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_owner_d   = s1_owner_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    ars_d        = ars_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rzero_d      = rzero_q;
    rtag_d       = rtag_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;

    // Drain first so that a same-cycle refill from S1 wins.
    for (int unsigned p = 0; p < 2; p++) begin
      if (rvalid_q[p] && resp_ready_v[p]) begin
        rvalid_d[p] = 1'b0;
      end
      if (s1_adv && (s1_owner_q == 1'(p))) begin
        rvalid_d[p] = 1'b1;
        rdata_d[p]  = alu_Out;
        rzero_d[p]  = alu_Zero;
        rtag_d[p]   = tag_q;
      end
    end

    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (in0_ready || in1_ready) begin
      s1_valid_d   = 1'b1;
      s1_owner_d   = in1_ready;
      last_grant_d = in1_ready;
      if (in1_ready) begin
        opcode_d = in1_opcode;
        funct_d  = in1_funct;
        ars_d    = in1_add_rshift_type;
        a_d      = in1_A;
        b_d      = in1_B;
        tag_d    = in1_tag;
      end else begin
        opcode_d = in0_opcode;
        funct_d  = in0_funct;
        ars_d    = in0_add_rshift_type;
        a_d      = in0_A;
        b_d      = in0_B;
        tag_d    = in0_tag;
      end
    end

    if ((in0_valid || in1_valid) && !can_accept && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_owner_q   <= 1'b0;
      opcode_q     <= '0;
      funct_q      <= '0;
      ars_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '{default: '0};
      rzero_q      <= '0;
      rtag_q       <= '{default: '0};
      last_grant_q <= 1'b1;
      stall_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_owner_q   <= s1_owner_d;
      opcode_q     <= opcode_d;
      funct_q      <= funct_d;
      ars_q        <= ars_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rzero_q      <= rzero_d;
      rtag_q       <= rtag_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    alu_opcode          = opcode_q;
    alu_funct           = funct_q;
    alu_add_rshift_type = ars_q;
    alu_A               = a_q;
    alu_B               = b_q;
    resp0_valid         = rvalid_q[0];
    resp0_data          = rdata_q[0];
    resp0_zero          = rzero_q[0];
    resp0_tag           = rtag_q[0];
    resp1_valid         = rvalid_q[1];
    resp1_data          = rdata_q[1];
    resp1_zero          = rzero_q[1];
    resp1_tag           = rtag_q[1];
    busy                = s1_valid_q | rvalid_q[0] | rvalid_q[1];
    stall_cnt           = stall_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: drives an ALU model on alu_*, checks every cycle against a
// transaction-level model, plus directed literal checks for the key scenarios.
module tb_alu_arbiter;
  localparam int unsigned TAGW = 4;
  localparam int unsigned CNTW = 4;
  localparam int unsigned SMAX = (1 << CNTW) - 1;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct;
    logic            ars;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TAGW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]     data;
    logic            zero;
    logic [TAGW-1:0] tag;
  } rsp_t;

  typedef struct packed {
    logic        port;
    logic        zero;
    logic [31:0] data;
  } log_t;

  logic            Clock, Reset_n;
  logic            in0_valid, in0_ready, in0_add_rshift_type;
  logic [6:0]      in0_opcode;
  logic [2:0]      in0_funct;
  logic [31:0]     in0_A, in0_B;
  logic [TAGW-1:0] in0_tag;
  logic            in1_valid, in1_ready, in1_add_rshift_type;
  logic [6:0]      in1_opcode;
  logic [2:0]      in1_funct;
  logic [31:0]     in1_A, in1_B;
  logic [TAGW-1:0] in1_tag;
  logic [6:0]      alu_opcode;
  logic [2:0]      alu_funct;
  logic            alu_add_rshift_type;
  logic [31:0]     alu_A, alu_B, alu_Out;
  logic            alu_Zero;
  logic            resp0_valid, resp0_ready, resp0_zero;
  logic [31:0]     resp0_data;
  logic [TAGW-1:0] resp0_tag;
  logic            resp1_valid, resp1_ready, resp1_zero;
  logic [31:0]     resp1_data;
  logic [TAGW-1:0] resp1_tag;
  logic            busy;
  logic [CNTW-1:0] stall_cnt;

  alu_arbiter #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_opcode(in0_opcode),
    .in0_funct(in0_funct), .in0_add_rshift_type(in0_add_rshift_type),
    .in0_A(in0_A), .in0_B(in0_B), .in0_tag(in0_tag),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_opcode(in1_opcode),
    .in1_funct(in1_funct), .in1_add_rshift_type(in1_add_rshift_type),
    .in1_A(in1_A), .in1_B(in1_B), .in1_tag(in1_tag),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_add_rshift_type(alu_add_rshift_type), .alu_A(alu_A), .alu_B(alu_B),
    .alu_Out(alu_Out), .alu_Zero(alu_Zero),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp0_zero(resp0_zero), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .resp1_zero(resp1_zero), .resp1_tag(resp1_tag),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RV32 ALUdec+ALU behaviour; returns {zero, result}.
  function automatic logic [32:0] alu_f(logic [6:0] op, logic [2:0] f, logic ars,
                                        logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    if (op == OPC_ARI_RTYPE || op == OPC_ARI_ITYPE) begin
      case (f)
        3'b000:  r = (op == OPC_ARI_RTYPE && ars) ? a - b : a + b;
        3'b001:  r = a << b[4:0];
        3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'b011:  r = (a < b) ? 32'd1 : 32'd0;
        3'b100:  r = a ^ b;
        3'b101:  r = ars ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110:  r = a | b;
        default: r = a & b;
      endcase
    end else if (op == OPC_BRANCH) begin
      case (f)
        3'b000, 3'b001: r = a - b;
        3'b100, 3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default:        r = (a < b) ? 32'd1 : 32'd0;
      endcase
    end
    return {(r == 32'd0), r};
  endfunction

  always_comb {alu_Zero, alu_Out} = alu_f(alu_opcode, alu_funct, alu_add_rshift_type, alu_A, alu_B);

  function automatic rsp_t exp_of(req_t r);
    logic [32:0] x;
    x = alu_f(r.opcode, r.funct, r.ars, r.a, r.b);
    return '{data: x[31:0], zero: x[32], tag: r.tag};
  endfunction

  function automatic req_t mk(logic [6:0] op, logic [2:0] f, logic ars,
                              logic [31:0] a, logic [31:0] b, logic [TAGW-1:0] tag);
    return '{opcode: op, funct: f, ars: ars, a: a, b: b, tag: tag};
  endfunction

  function automatic bit same(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  int unsigned m_total, m_pass, d_total, d_pass;

  task automatic mchk(string name, logic [31:0] act, logic [31:0] exp);
    m_total++;
    if (same(name, act, exp)) m_pass++;
  endtask

  task automatic dchk(string name, logic [31:0] act, logic [31:0] exp);
    d_total++;
    if (same(name, act, exp)) d_pass++;
  endtask

  // Transaction-level model: one issue slot, one result slot per port.
  logic        m_last, m_s1_v, m_s1_own;
  req_t        m_s1_r;
  rsp_t        m_s1_e;
  logic [1:0]  m_rv;
  rsp_t        m_re [2];
  int unsigned m_stall;
  logic        f0, f1;
  logic        grant_log [$];
  log_t        rsp_log [$];

  always @(negedge Clock or negedge Reset_n) begin : model
    logic       blocked, g0, g1, acc;
    logic [1:0] rr;
    req_t       r;
    if (!Reset_n) begin
      m_last  = 1'b1;
      m_s1_v  = 1'b0;
      m_rv    = 2'b00;
      m_stall = 0;
      f0      = 1'b0;
      f1      = 1'b0;
    end else begin
      rr      = {resp1_ready, resp0_ready};
      blocked = m_s1_v && m_rv[m_s1_own] && !rr[m_s1_own];
      acc     = !blocked;
      g0      = in0_valid && (!in1_valid || m_last);
      g1      = in1_valid && (!in0_valid || !m_last);

      mchk("in0_ready", 32'(in0_ready), 32'(acc && g0));
      mchk("in1_ready", 32'(in1_ready), 32'(acc && g1));
      mchk("resp0_valid", 32'(resp0_valid), 32'(m_rv[0]));
      mchk("resp1_valid", 32'(resp1_valid), 32'(m_rv[1]));
      if (m_rv[0]) begin
        mchk("resp0_data", resp0_data, m_re[0].data);
        mchk("resp0_zero", 32'(resp0_zero), 32'(m_re[0].zero));
        mchk("resp0_tag", 32'(resp0_tag), 32'(m_re[0].tag));
      end
      if (m_rv[1]) begin
        mchk("resp1_data", resp1_data, m_re[1].data);
        mchk("resp1_zero", 32'(resp1_zero), 32'(m_re[1].zero));
        mchk("resp1_tag", 32'(resp1_tag), 32'(m_re[1].tag));
      end
      mchk("busy", 32'(busy), 32'(m_s1_v || m_rv != 2'b00));
      mchk("stall_cnt", 32'(stall_cnt), m_stall);
      if (m_s1_v) begin
        mchk("alu_opcode", 32'(alu_opcode), 32'(m_s1_r.opcode));
        mchk("alu_funct", 32'(alu_funct), 32'(m_s1_r.funct));
        mchk("alu_ars", 32'(alu_add_rshift_type), 32'(m_s1_r.ars));
        mchk("alu_A", alu_A, m_s1_r.a);
        mchk("alu_B", alu_B, m_s1_r.b);
      end

      f0 = in0_valid && in0_ready;
      f1 = in1_valid && in1_ready;

      if (m_rv[0] && rr[0]) begin
        rsp_log.push_back('{port: 1'b0, zero: resp0_zero, data: resp0_data});
        m_rv[0] = 1'b0;
      end
      if (m_rv[1] && rr[1]) begin
        rsp_log.push_back('{port: 1'b1, zero: resp1_zero, data: resp1_data});
        m_rv[1] = 1'b0;
      end
      if (m_s1_v && !blocked) begin
        m_re[m_s1_own] = m_s1_e;
        m_rv[m_s1_own] = 1'b1;
        m_s1_v = 1'b0;
      end
      if (acc && (g0 || g1)) begin
        r = g1 ? mk(in1_opcode, in1_funct, in1_add_rshift_type, in1_A, in1_B, in1_tag)
               : mk(in0_opcode, in0_funct, in0_add_rshift_type, in0_A, in0_B, in0_tag);
        m_s1_r   = r;
        m_s1_e   = exp_of(r);
        m_s1_v   = 1'b1;
        m_s1_own = g1;
        m_last   = g1;
        grant_log.push_back(g1);
      end
      if ((in0_valid || in1_valid) && blocked && m_stall < SMAX) m_stall++;
    end
  end

  req_t q0 [$];
  req_t q1 [$];

  task automatic drive();
    in0_valid = (q0.size() != 0);
    in1_valid = (q1.size() != 0);
    if (q0.size() != 0) begin
      in0_opcode = q0[0].opcode; in0_funct = q0[0].funct; in0_add_rshift_type = q0[0].ars;
      in0_A = q0[0].a; in0_B = q0[0].b; in0_tag = q0[0].tag;
    end
    if (q1.size() != 0) begin
      in1_opcode = q1[0].opcode; in1_funct = q1[0].funct; in1_add_rshift_type = q1[0].ars;
      in1_A = q1[0].a; in1_B = q1[0].b; in1_tag = q1[0].tag;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (f0 && q0.size() != 0) void'(q0.pop_front());
    if (f1 && q1.size() != 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !busy) && n < budget) begin
      step();
      n++;
    end
    d_total++;
    if (n < budget) d_pass++;
    else $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
  endtask

  task automatic reset_dut();
    q0.delete();
    q1.delete();
    drive();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stim
    int unsigned gb, rb;
    m_total = 0; m_pass = 0; d_total = 0; d_pass = 0;
    in0_valid = 0; in0_opcode = '0; in0_funct = '0; in0_add_rshift_type = 0;
    in0_A = '0; in0_B = '0; in0_tag = '0;
    in1_valid = 0; in1_opcode = '0; in1_funct = '0; in1_add_rshift_type = 0;
    in1_A = '0; in1_B = '0; in1_tag = '0;
    resp0_ready = 0; resp1_ready = 0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    dchk("rst_busy", 32'(busy), 0);
    dchk("rst_stall", 32'(stall_cnt), 0);
    dchk("rst_alu_opcode", 32'(alu_opcode), 0);
    dchk("rst_alu_A", alu_A, 0);
    dchk("rst_resp0_data", resp0_data, 0);
    dchk("rst_resp1_valid", 32'(resp1_valid), 0);

    // Single ADD: 12 + 5 -> 17 after two edges
    resp0_ready = 1; resp1_ready = 1;
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd12, 32'd5, 4'd3));
    drive();
    #1;
    dchk("add_in0_ready", 32'(in0_ready), 1);
    step();
    step();
    dchk("add_resp0_valid", 32'(resp0_valid), 1);
    dchk("add_resp0_data", resp0_data, 32'd17);
    dchk("add_resp0_zero", 32'(resp0_zero), 0);
    dchk("add_resp0_tag", 32'(resp0_tag), 3);
    step();
    dchk("add_busy_after", 32'(busy), 0);

    // Tie after reset: strict alternation starting at port 0
    reset_dut();
    resp0_ready = 1; resp1_ready = 1;
    gb = grant_log.size(); rb = rsp_log.size();
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd1, 32'd2, 4'd1));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b100, 1'b0, 32'hF0, 32'hFF, 4'd2));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd3));
    q0.push_back(mk(OPC_ARI_ITYPE, 3'b001, 1'b0, 32'd1, 32'd4, 4'd4));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b1, 32'h20, 32'h20, 4'd5));
    q1.push_back(mk(OPC_ARI_ITYPE, 3'b000, 1'b0, 32'd100, 32'd23, 4'd6));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b110, 1'b0, 32'h0F, 32'h30, 4'd7));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b111, 1'b0, 32'h3C, 32'h0F, 4'd8));
    drive();
    wait_idle(40);
    dchk("tie_grants", grant_log.size() - gb, 8);
    dchk("tie_resps", rsp_log.size() - rb, 8);
    if (grant_log.size() >= gb + 8 && rsp_log.size() >= rb + 8) begin
      for (int unsigned i = 0; i < 8; i++) begin
        dchk("tie_grant_order", 32'(grant_log[gb+i]), i % 2);
        dchk("tie_resp_order", 32'(rsp_log[rb+i].port), i % 2);
      end
      dchk("tie_sub_data", rsp_log[rb+1].data, 0);
      dchk("tie_sub_zero", 32'(rsp_log[rb+1].zero), 1);
    end

    // Backpressure on resp0: op1 in resp0, op2 in S1, both readies drop
    reset_dut();
    resp0_ready = 0; resp1_ready = 1;
    gb = grant_log.size();
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd10, 32'd1, 4'd1));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd10, 32'd2, 4'd2));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd10, 32'd3, 4'd3));
    drive();
    step();
    step();
    dchk("bp_resp0_valid", 32'(resp0_valid), 1);
    dchk("bp_resp0_data", resp0_data, 32'd11);
    dchk("bp_alu_B_op2", alu_B, 32'd2);
    q1.push_back(mk(OPC_ARI_ITYPE, 3'b000, 1'b0, 32'h100, 32'h4, 4'hA));
    drive();
    #1;
    dchk("bp_in0_ready", 32'(in0_ready), 0);
    dchk("bp_in1_ready", 32'(in1_ready), 0);
    repeat (5) step();
    dchk("bp_stall_cnt", 32'(stall_cnt), 5);
    resp0_ready = 1;
    #1;
    dchk("bp_recover_in1", 32'(in1_ready), 1);
    dchk("bp_recover_in0", 32'(in0_ready), 0);
    wait_idle(40);
    dchk("bp_stall_final", 32'(stall_cnt), 5);
    if (grant_log.size() >= gb + 4) begin
      dchk("bp_grant3", 32'(grant_log[gb+2]), 1);
      dchk("bp_grant4", 32'(grant_log[gb+3]), 0);
    end else begin
      dchk("bp_grant_count", grant_log.size() - gb, 4);
    end

    // BLT: 0x80000000 < 1 signed
    resp0_ready = 1;
    q0.push_back(mk(OPC_BRANCH, 3'b100, 1'b0, 32'h8000_0000, 32'd1, 4'h9));
    drive();
    step();
    step();
    dchk("blt_valid", 32'(resp0_valid), 1);
    dchk("blt_data", resp0_data, 32'd1);
    dchk("blt_tag", 32'(resp0_tag), 32'h9);
    wait_idle(20);

    // Mid-flight reset with S1 and resp1 occupied
    reset_dut();
    resp0_ready = 1; resp1_ready = 0;
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd1, 32'd1, 4'd1));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd2, 32'd2, 4'd2));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd3, 32'd3, 4'd3));
    drive();
    repeat (3) step();
    dchk("mr_pre_stall", 32'(stall_cnt), 1);
    dchk("mr_pre_resp1", 32'(resp1_valid), 1);
    dchk("mr_pre_busy", 32'(busy), 1);
    #1;
    q1.delete();
    drive();
    Reset_n = 1'b0;
    #1;
    dchk("mr_resp1_valid", 32'(resp1_valid), 0);
    dchk("mr_resp0_valid", 32'(resp0_valid), 0);
    dchk("mr_busy", 32'(busy), 0);
    dchk("mr_stall", 32'(stall_cnt), 0);
    Reset_n = 1'b1;
    resp1_ready = 1;
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd7, 32'd7, 4'd4));
    q1.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd8, 32'd8, 4'd5));
    drive();
    #1;
    dchk("mr_tie_in0", 32'(in0_ready), 1);
    dchk("mr_tie_in1", 32'(in1_ready), 0);
    wait_idle(20);

    // Saturation of the 4-bit stall counter
    reset_dut();
    resp0_ready = 0; resp1_ready = 1;
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd5, 32'd1, 4'd1));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd5, 32'd2, 4'd2));
    q0.push_back(mk(OPC_ARI_RTYPE, 3'b000, 1'b0, 32'd5, 32'd3, 4'd3));
    drive();
    step();
    step();
    repeat (20) step();
    dchk("sat_stall", 32'(stall_cnt), 32'hF);
    repeat (3) step();
    dchk("sat_stall_hold", 32'(stall_cnt), 32'hF);
    resp0_ready = 1;
    wait_idle(20);

    $display("%0d/%0d checks passed", m_pass + d_pass, m_total + d_total);
    $finish;
  end

endmodule
